// File: rtl/jk_flip_flop_if.sv
// jk_flip_flop_if
//   Bundles the data-side signals of the JK flip-flop so that the stimulus
//   side and the flip-flop connect through one port each.
//   Clock and reset are not part of the bundle; they stay plain ports.
//
//   Signals:
//     j   - J input, set request
//     k   - K input, reset request
//     s_  - synchronous preset, active-low
//     r_  - synchronous clear, active-low
//     Q   - stored state
//     Q_  - complement of Q
//
//   Modports:
//     master - drives j/k/s_/r_ and observes Q/Q_
//     slave  - the flip-flop itself
interface jk_flip_flop_if;
   logic j;
   logic k;
   logic s_;
   logic r_;
   logic Q;
   logic Q_;

   modport master (
      output j,
      output k,
      output s_,
      output r_,
      input  Q,
      input  Q_
   );

   modport slave (
      input  j,
      input  k,
      input  s_,
      input  r_,
      output Q,
      output Q_
   );
endinterface

// File: rtl/jk_flip_flop.sv
// jk_flip_flop
//   Single-bit rising-edge JK flip-flop with synchronous active-high reset
//   and synchronous active-low preset/clear.
//
//   Priority at each rising edge of cp, highest first:
//     rst=1 -> 0, r_=0 -> 0, s_=0 -> 1, then JK:
//     00 hold, 01 clear, 10 set, 11 toggle.
//
//   Ports:
//     cp   - clock, all state changes on its rising edge
//     rst  - synchronous reset, active-high
//     bus  - jk_flip_flop_if.slave: j, k, s_, r_ in; Q, Q_ out
module jk_flip_flop (
   input logic          cp,
   input logic          rst,
   jk_flip_flop_if.slave bus
);

   logic q_q;
   logic q_d;

   // Next-state for the non-reset path. Clear is checked before preset so
   // that clear wins when both are low.
   always_comb begin
      q_d = q_q;
      if (!bus.r_) begin
         q_d = 1'b0;
      end else if (!bus.s_) begin
         q_d = 1'b1;
      end else begin
         unique case ({bus.j, bus.k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   // Outputs come straight from the register: no input-to-output path.
   assign bus.Q  = q_q;
   assign bus.Q_ = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// tb_jk_flip_flop
//   Directed test of jk_flip_flop. Inputs change on the falling edge of cp;
//   outputs are checked 1 time unit after each rising edge against
//   hand-computed expected values.
module tb_jk_flip_flop;

   logic cp;
   logic rst;
   int   total;
   int   bad;

   jk_flip_flop_if bus ();

   jk_flip_flop dut (
      .cp  (cp),
      .rst (rst),
      .bus (bus.slave)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic check(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one rising edge, check Q and Q_, then return on the falling edge
   // so the caller can change inputs away from the active edge.
   task automatic tick(input string tag, input logic exp_q);
      @(posedge cp);
      #1;
      check({tag, ".Q"}, bus.Q, exp_q);
      check({tag, ".Q_"}, bus.Q_, ~exp_q);
      @(negedge cp);
   endtask

   task automatic drive(input logic r, input logic jj, input logic kk,
                        input logic ss, input logic rr);
      rst    = r;
      bus.j  = jj;
      bus.k  = kk;
      bus.s_ = ss;
      bus.r_ = rr;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Reset with j=k=1 must still give 0.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick("reset", 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick("rst_release0", 1'b0);
      tick("rst_release1", 1'b0);

      // JK truth table from Q=0.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick("jk_set", 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick("jk_hold1", 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick("jk_clear", 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick("jk_hold0", 1'b0);

      // Continuous toggle.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick("toggle0", 1'b1);
      tick("toggle1", 1'b0);
      tick("toggle2", 1'b1);
      tick("toggle3", 1'b0);

      // Preset/clear override a toggling JK.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick("clear0", 1'b0);
      tick("clear1", 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick("preset0", 1'b1);
      tick("preset1", 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick("release_toggle", 1'b0);

      // Priority: clear beats preset, reset beats preset.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("preset_again", 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("clear_over_preset", 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("preset_before_rst", 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("rst_over_preset", 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick("rst_held", 1'b0);

      // Set Q=1, then pulse r_ low between edges: no effect.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("preset_for_glitch", 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick("hold_before_glitch", 1'b1);
      #1 bus.r_ = 1'b0;
      #1 check("mid_pulse.Q", bus.Q, 1'b1);
      #1 bus.r_ = 1'b1;
      tick("after_glitch", 1'b1);

      // Toggle resumes from the held value.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick("final_toggle", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
